// File: rtl/as_pkg.sv
`default_nettype none
// ============================================================================
// Package : as_pkg
// Brief   : Shared opcode, state encoding and bit-level helper for the
//           bit-serial add/subtract unit.
// Rev     : 1.0  initial release
// ============================================================================
package as_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 2'd3 is never entered; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Majority of three: carry out of a full-adder cell.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module : full_adder
// Brief  : Single full-adder cell; the only arithmetic in the serial unit.
// Rev    : 1.0  initial release
// ============================================================================
module full_adder
  import as_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = maj3(i_a, i_b, i_cin);

endmodule
`default_nettype wire

// File: rtl/serial_as_unit.sv
`default_nettype none
// ============================================================================
// Module : serial_as_unit
// Brief  : Bit-serial two's-complement add/subtract with valid/ready request
//          and response handshakes. One bit per cycle, LSB first.
// Rev    : 1.0  initial release
// ============================================================================
module serial_as_unit
  import as_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int               CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_alive;     // low while in reset, keeps in_ready at 0
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;         // already inverted for SUB
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_take;
  logic             w_last;
  logic             w_s;
  logic             w_cout;

  assign out_valid = (r_state == ST_DONE);
  assign in_ready  = r_alive & ((r_state == ST_IDLE) |
                                ((r_state == ST_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_take    = out_valid & out_ready;
  assign w_last    = (r_cnt == C_LAST);

  assign result    = r_res;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // State register plus the reset-release flag gating in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
    end
  end

  // Next-state logic; a take and a new accept in DONE go straight to RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_DONE;
      ST_DONE: begin
        if (w_accept)    w_next = ST_RUN;
        else if (w_take) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, serial bit processing and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b ^ {WIDTH{opcode}};
      r_c   <= (opcode == OP_SUB);   // +1 completes A + ~B + 1
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cout;
      r_res <= {w_s, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        // r_c here is the carry into the MSB.
        r_carry <= w_cout;
        r_ovf   <= r_c ^ w_cout;
      end
    end
  end

endmodule
`default_nettype wire
